// File: rtl/gsim_pkg.sv
// Shared constants, helpers and FSM encoding for the gsim_solver Gauss-Seidel block.
package gsim_pkg;

  localparam int unsigned N      = 16;
  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned FRAC_W = 16;
  localparam int unsigned ACC_W  = 48;
  localparam int unsigned B_W    = 16;
  localparam int unsigned X_W    = 32;

  // Magnitudes of the band coefficients; the signs are applied in gsim_update.
  localparam int unsigned C_DIAG = 20;
  localparam int unsigned C_OFF1 = 13;
  localparam int unsigned C_OFF2 = 6;
  localparam int unsigned C_OFF3 = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    OUT
  } state_t;

  function automatic logic [ACC_W-1:0] sext_x(input logic [X_W-1:0] v);
    return {{(ACC_W-X_W){v[X_W-1]}}, v};
  endfunction

endpackage

// File: rtl/gsim_update.sv
// One Gauss-Seidel row update: 7-tap band sum, round-to-nearest divide by 20, saturate to Q16.16.
module gsim_update
  import gsim_pkg::*;
(
  input  logic [B_W-1:0] b_val,
  input  logic [X_W-1:0] xm1,
  input  logic [X_W-1:0] xm2,
  input  logic [X_W-1:0] xm3,
  input  logic [X_W-1:0] xp1,
  input  logic [X_W-1:0] xp2,
  input  logic [X_W-1:0] xp3,
  output logic [X_W-1:0] x_new
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mag;
  logic [ACC_W-1:0] quo;
  logic             neg;

  // Two's-complement arithmetic modulo 2^ACC_W; the sum never reaches the top bit.
  always_comb begin
    acc = ({{(ACC_W-B_W){b_val[B_W-1]}}, b_val} << FRAC_W)
        + ACC_W'(C_OFF1) * (sext_x(xm1) + sext_x(xp1))
        - ACC_W'(C_OFF2) * (sext_x(xm2) + sext_x(xp2))
        + ACC_W'(C_OFF3) * (sext_x(xm3) + sext_x(xp3));
    neg = acc[ACC_W-1];
    mag = neg ? -acc : acc;
    // Rounding the magnitude gives ties-away-from-zero for both signs.
    quo = (mag + ACC_W'(C_DIAG / 2)) / ACC_W'(C_DIAG);
    if (!neg && quo > ACC_W'(32'h7FFF_FFFF)) begin
      x_new = 32'h7FFF_FFFF;
    end else if (neg && quo > ACC_W'(32'h8000_0000)) begin
      x_new = 32'h8000_0000;
    end else begin
      x_new = neg ? -quo[X_W-1:0] : quo[X_W-1:0];
    end
  end

endmodule

// File: rtl/gsim_solver.sv
// Gauss-Seidel solver for the fixed 16x16 banded system; streams b in, x (Q16.16) out.
// Optional macro GSIM_EARLY_STOP_EN: leave CALC after a sweep in which no x changed.
module gsim_solver
  import gsim_pkg::*;
#(
  parameter int unsigned ITER = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [15:0] b_in,
  output logic        out_valid,
  output logic [31:0] x_out
);

  localparam int unsigned SW_W = $clog2(ITER + 1);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] cnt;
  logic [SW_W-1:0]  sweep;
  logic [B_W-1:0]   b_mem [N];
  logic [X_W-1:0]   x_mem [N];
  logic [X_W-1:0]   xm [3];
  logic [X_W-1:0]   xp [3];
  logic [X_W-1:0]   x_new;
  logic             last_idx;
  logic             last_sweep;
  logic             sweep_done;

  assign last_idx   = (cnt == IDX_W'(N - 1));
  assign last_sweep = (sweep == SW_W'(ITER - 1));

`ifdef GSIM_EARLY_STOP_EN
  logic changed;
  logic sweep_changed;

  // A sweep with no change leaves x at a fixed point, so later sweeps would repeat it exactly.
  assign sweep_changed = changed || (x_new != x_mem[cnt]);
  assign sweep_done    = last_sweep || !sweep_changed;

  always_ff @(posedge clk) begin
    if (reset) begin
      changed <= 1'b0;
    end else if (state == CALC) begin
      changed <= last_idx ? 1'b0 : sweep_changed;
    end else begin
      changed <= 1'b0;
    end
  end
`else
  assign sweep_done = last_sweep;
`endif

  always_comb begin
    for (int unsigned k = 0; k < 3; k++) begin
      xm[k] = '0;
      xp[k] = '0;
      if (32'(cnt) >= k + 1) xm[k] = x_mem[cnt - IDX_W'(k + 1)];
      if (32'(cnt) + k + 1 < N) xp[k] = x_mem[cnt + IDX_W'(k + 1)];
    end
  end

  gsim_update u_update (
    .b_val (b_mem[cnt]),
    .xm1   (xm[0]),
    .xm2   (xm[1]),
    .xm3   (xm[2]),
    .xp1   (xp[0]),
    .xp2   (xp[1]),
    .xp3   (xp[2]),
    .x_new (x_new)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, LOAD: if (in_en) state_nx = last_idx ? CALC : LOAD;
      CALC:       if (last_idx && sweep_done) state_nx = OUT;
      OUT:        if (last_idx) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    x_out     = '0;
    if (state == OUT) begin
      out_valid = 1'b1;
      x_out     = x_mem[cnt];
    end
  end

  // cnt is shared: load index, row being updated, and output index.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      sweep <= '0;
      for (int unsigned j = 0; j < N; j++) begin
        b_mem[j] <= '0;
        x_mem[j] <= '0;
      end
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (in_en) begin
            b_mem[cnt] <= b_in;
            cnt        <= last_idx ? '0 : cnt + IDX_W'(1);
            if (last_idx) begin
              sweep <= '0;
              for (int unsigned j = 0; j < N; j++) x_mem[j] <= '0;
            end
          end
        end
        CALC: begin
          x_mem[cnt] <= x_new;
          cnt        <= last_idx ? '0 : cnt + IDX_W'(1);
          if (last_idx) sweep <= sweep_done ? '0 : sweep + SW_W'(1);
        end
        OUT: begin
          cnt <= last_idx ? '0 : cnt + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_solver.sv
// Directed self-checking bench for gsim_solver (default ITER, band matrix 20/-13/6/-1).
module tb_gsim_solver;

  typedef int          vec_t  [16];
  typedef logic [31:0] wvec_t [16];

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [15:0] b_in;
  logic        out_valid;
  logic [31:0] x_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_first  = 0;
  int t_last   = 0;

  vec_t  zv, uv, nv, xs, bv;
  wvec_t got, got_a, got_b;

  gsim_solver dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .b_in      (b_in),
    .out_valid (out_valid),
    .x_out     (x_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int coef(input int d);
    case (d)
      0:       return 20;
      1, -1:   return -13;
      2, -2:   return 6;
      3, -3:   return -1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] obs, input int exp, input int tol);
    int d;
    logic ok;
    d  = int'(obs) - exp;
    ok = !$isunknown(obs) && (d >= -tol) && (d <= tol);
    checks++;
    assert (ok === 1'b1) else begin
      failures++;
      $error("FAIL %s: got %h expected %h +-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic load(input vec_t v, input int gap_after, input int gap_len);
    for (int w = 0; w < 16; w++) begin
      @(posedge clk); #1;
      in_en = 1'b1;
      b_in  = 16'(v[w]);
      if (w == 0) t_first = cyc;
      if (w == gap_after) begin
        repeat (gap_len) begin
          @(posedge clk); #1;
          in_en = 1'b0;
          b_in  = 16'hDEAD;
        end
      end
    end
    @(posedge clk); #1;
    in_en = 1'b0;
  endtask

  task automatic collect(output wvec_t g, input bit noise);
    int n;
    n = 0;
    for (int w = 0; w < 16; w++) g[w] = 'x;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 6000);
    if (out_valid !== 1'b1) begin
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
    end else begin
      for (int w = 0; w < 16; w++) begin
        if (w > 0) begin
          @(negedge clk);
          chk($sformatf("out_valid_w%0d", w), 32'(out_valid), 32'd1);
        end
        g[w]   = x_out;
        t_last = cyc;
        if (noise) begin
          in_en = (w < 15);
          b_in  = 16'(w * 977);
        end
      end
      in_en = 1'b0;
    end
  endtask

  task automatic calc_noise();
    repeat (5) begin
      @(posedge clk); #1;
      in_en = 1'b1;
      b_in  = 16'h7FFF;
    end
    @(posedge clk); #1;
    in_en = 1'b0;
  endtask

  initial begin
    int   bad;
    real  r, ss;

    reset = 1'b1;
    in_en = 1'b0;
    b_in  = '0;

    zv = '{default: 0};
    uv = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
    for (int i = 0; i < 16; i++) nv[i] = -uv[i];
    xs = '{700, -350, 123, -500, 0, 250, -700, 45, 600, -1, -300, 77, 400, -650, 10, 333};
    for (int i = 0; i < 16; i++) begin
      bv[i] = 0;
      for (int j = 0; j < 16; j++) bv[i] += coef(i - j) * xs[j];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_x_out", x_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Zero vector, exact outputs, exact window length and latency.
    load(zv, -1, 0);
    collect(got, 1'b0);
    for (int w = 0; w < 16; w++) chk($sformatf("zero_w%0d", w), got[w], 32'd0);
    @(negedge clk);
    chk("zero_valid_drop", 32'(out_valid), 32'd0);
    chk("zero_x_out_idle", x_out, 32'd0);
`ifndef GSIM_EARLY_STOP_EN
    chk("latency_zero", 32'(t_last - t_first), 32'd4127);
`endif

    // Unit solution.
    load(uv, -1, 0);
    collect(got, 1'b0);
    for (int w = 0; w < 16; w++) chk_tol($sformatf("unit_w%0d", w), got[w], 65536, 2);

    // Negated unit solution.
    load(nv, -1, 0);
    collect(got, 1'b0);
    for (int w = 0; w < 16; w++) chk_tol($sformatf("negunit_w%0d", w), got[w], -65536, 2);

    // Mixed vector with known integer solution, plus residual.
    load(bv, -1, 0);
    collect(got, 1'b0);
    for (int w = 0; w < 16; w++) chk_tol($sformatf("mixed_w%0d", w), got[w], xs[w] * 65536, 2);
    ss = 0.0;
    for (int i = 0; i < 16; i++) begin
      r = -real'(bv[i]);
      for (int j = 0; j < 16; j++) r += real'(coef(i - j)) * (real'(int'(got[j])) / 65536.0);
      ss += r * r;
    end
    checks++;
    assert (ss < 1.0e-6) else begin
      failures++;
      $error("FAIL mixed_residual: got %g expected < 1e-6", ss);
    end

    // Reset during sweep 10 aborts the frame.
    load(uv, -1, 0);
    repeat (16 * 10 + 3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    repeat (4300) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || x_out !== 32'd0) bad++;
    end
    chk("reset_abort_quiet", 32'(bad), 32'd0);
    load(uv, -1, 0);
    collect(got, 1'b0);
    for (int w = 0; w < 16; w++) chk_tol($sformatf("post_reset_w%0d", w), got[w], 65536, 2);

    // Gapped load, ignored in_en during CALC/OUT, then a back-to-back frame.
    load(uv, 7, 3);
    calc_noise();
    collect(got_a, 1'b1);
`ifndef GSIM_EARLY_STOP_EN
    chk("latency_gap", 32'(t_last - t_first), 32'd4130);
`endif
    load(bv, -1, 0);
    collect(got_b, 1'b0);
    for (int w = 0; w < 16; w++) chk_tol($sformatf("b2b_a_w%0d", w), got_a[w], 65536, 2);
    for (int w = 0; w < 16; w++) chk_tol($sformatf("b2b_b_w%0d", w), got_b[w], xs[w] * 65536, 2);
    @(negedge clk);
    chk("b2b_valid_drop", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
